pc_sequencer: RTL and testbench

- Registered program-counter sequencer for the 16-bit RISC core. Generalised successor to the combinational next-PC logic.
- Holds the PC register and selects the next PC from these sources: sequential, branch, jump/call, return, trap.
- Contains a parametrised return-address stack (RAS), a stall hold, and a registered redirect pulse for fetch/decode flush.
- Sits between the decode/ALU feedback signals and the instruction-memory address port.

---
 rtl/pc_pkg.sv | 31 +++
 rtl/ras_stack.sv | 56 +++++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and helpers for the program-counter sequencer.
//   pc_src_e   - which source produced the next PC
//   sext_scale - sign-extend a raw offset field and scale it to bytes
package pc_pkg;

   typedef enum logic [2:0] {
      SRC_SEQ,
      SRC_BR,
      SRC_JMP,
      SRC_RET,
      SRC_TRAP
   } pc_src_e;

   localparam int unsigned MAX_W = 64;

   // Sign-extends the low w bits of raw to MAX_W bits, then shifts left by
   // shift. Callers truncate the result to their own address width.
   function automatic logic [MAX_W-1:0] sext_scale(
      input logic [MAX_W-1:0] raw,
      input int unsigned      w,
      input int unsigned      shift
   );
      logic [MAX_W-1:0] v;
      v = raw;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i >= w) v[i] = raw[w-1];
      end
      return v << shift;
   endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack with a saturating entry count.
//   clk, rst  - clock, synchronous active-high reset
//   i_push    - write i_data at the pointer and advance (takes priority)
//   i_pop     - retreat the pointer when not empty
//   i_data    - link address to push
//   o_top     - entry just below the pointer (most recent push)
//   o_count   - number of valid entries (saturates at DEPTH)
//   o_empty   - o_count == 0
module ras_stack #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [W-1:0]             i_data,
   output logic [W-1:0]             o_top,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);

   localparam int unsigned        PW   = $clog2(DEPTH);
   localparam logic [PW:0]        FULL = (PW+1)'(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_ptr;
   logic [PW:0]   r_count;
   logic [PW-1:0] w_top_idx;

   assign w_top_idx = r_ptr - 1'b1;
   assign o_top     = r_mem[w_top_idx];
   assign o_count   = r_count;
   assign o_empty   = (r_count == '0);

   // Storage needs no reset: an entry is only read once count says it is valid.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_ptr] <= i_data;
   end

   // Pointer wraps naturally since DEPTH is a power of two; a push when full
   // overwrites the oldest entry and leaves the count pinned at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr   <= '0;
         r_count <= '0;
      end else if (i_push) begin
         r_ptr <= r_ptr + 1'b1;
         if (r_count != FULL) r_count <= r_count + 1'b1;
      end else if (i_pop && !o_empty) begin
         r_ptr   <= r_ptr - 1'b1;
         r_count <= r_count - 1'b1;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with next-PC selection.
//   clk, rst          - clock, synchronous active-high reset
//   stall             - hold PC and RAS (overridden by trap)
//   trap              - redirect to TRAP_VEC
//   jump / call       - PC-relative jump; call also pushes the link address
//   ret               - return to the RAS top (falls through when empty)
//   branch, branch_ne - conditional branch, NE when branch_ne else EQ
//   alu_zero          - ALU zero flag used by the branch condition
//   imm, jmp_off      - raw branch immediate / jump offset (in instructions)
//   pc, pc_next       - current PC (registered), next-PC candidate (comb)
//   redirect          - pulse: previous update took a non-sequential path
//   ras_count         - valid RAS entries
//   ras_underflow     - pulse: ret was taken with an empty RAS
module pc_sequencer
   import pc_pkg::*;
#(
   parameter int unsigned      XLEN        = 16,
   parameter int unsigned      INSTR_BYTES = 2,
   parameter int unsigned      IMM_W       = 16,
   parameter int unsigned      JOFF_W      = 12,
   parameter int unsigned      RAS_DEPTH   = 4,
   parameter logic [XLEN-1:0]  RESET_VEC   = 16'h0000,
   parameter logic [XLEN-1:0]  TRAP_VEC    = 16'h0004
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          stall,
   input  logic                          trap,
   input  logic                          jump,
   input  logic                          call,
   input  logic                          ret,
   input  logic                          branch,
   input  logic                          branch_ne,
   input  logic                          alu_zero,
   input  logic [IMM_W-1:0]              imm,
   input  logic [JOFF_W-1:0]             jmp_off,
   output logic [XLEN-1:0]               pc,
   output logic [XLEN-1:0]               pc_next,
   output logic                          redirect,
   output logic [$clog2(RAS_DEPTH):0]    ras_count,
   output logic                          ras_underflow
);

   localparam int unsigned SHIFT = $clog2(INSTR_BYTES);

   logic [XLEN-1:0] r_pc;
   logic            r_redirect;
   logic            r_underflow;

   logic [XLEN-1:0] w_seq;
   logic [XLEN-1:0] w_br_tgt;
   logic [XLEN-1:0] w_j_tgt;
   logic [XLEN-1:0] w_ras_top;
   logic            w_ras_empty;
   logic            w_taken;
   logic            w_update;
   logic            w_ras_op;
   logic            w_push;
   logic            w_pop;
   logic            w_ret_empty;
   pc_src_e         w_src;
   logic [XLEN-1:0] w_next;

   assign w_seq    = r_pc + XLEN'(INSTR_BYTES);
   assign w_br_tgt = w_seq + XLEN'(sext_scale(MAX_W'(imm), IMM_W, SHIFT));
   assign w_j_tgt  = w_seq + XLEN'(sext_scale(MAX_W'(jmp_off), JOFF_W, SHIFT));
   assign w_taken  = branch & (branch_ne ? ~alu_zero : alu_zero);

   always_comb begin
      w_src       = SRC_SEQ;
      w_next      = w_seq;
      w_ret_empty = 1'b0;
      if (trap) begin
         w_src  = SRC_TRAP;
         w_next = TRAP_VEC;
      end else if (call || jump) begin
         w_src  = SRC_JMP;
         w_next = w_j_tgt;
      end else if (ret) begin
         if (!w_ras_empty) begin
            w_src  = SRC_RET;
            w_next = w_ras_top;
         end else begin
            w_ret_empty = 1'b1;
         end
      end else if (w_taken) begin
         w_src  = SRC_BR;
         w_next = w_br_tgt;
      end
   end

   // Trap overrides stall for the PC, but the RAS only moves on a plain edge.
   assign w_update = ~stall | trap;
   assign w_ras_op = ~stall & ~trap;
   assign w_push   = w_ras_op & call;
   assign w_pop    = w_ras_op & (w_src == SRC_RET);

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (XLEN)
   ) u_ras (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_seq),
      .o_top   (w_ras_top),
      .o_count (ras_count),
      .o_empty (w_ras_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc        <= RESET_VEC;
         r_redirect  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= w_ras_op & w_ret_empty;
         if (w_update) begin
            r_pc       <= w_next;
            r_redirect <= (w_src != SRC_SEQ);
         end else begin
            r_redirect <= 1'b0;
         end
      end
   end

   assign pc            = r_pc;
   assign pc_next       = w_next;
   assign redirect      = r_redirect;
   assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst, stall, trap, jump, call, ret;
   logic        branch, branch_ne, alu_zero;
   logic [15:0] imm;
   logic [11:0] jmp_off;
   logic [15:0] pc, pc_next;
   logic        redirect, ras_underflow;
   logic [2:0]  ras_count;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   pc_sequencer #(
      .XLEN        (16),
      .INSTR_BYTES (2),
      .IMM_W       (16),
      .JOFF_W      (12),
      .RAS_DEPTH   (4),
      .RESET_VEC   (16'h0000),
      .TRAP_VEC    (16'h0004)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .trap          (trap),
      .jump          (jump),
      .call          (call),
      .ret           (ret),
      .branch        (branch),
      .branch_ne     (branch_ne),
      .alu_zero      (alu_zero),
      .imm           (imm),
      .jmp_off       (jmp_off),
      .pc            (pc),
      .pc_next       (pc_next),
      .redirect      (redirect),
      .ras_count     (ras_count),
      .ras_underflow (ras_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      stall = 0; trap = 0; jump = 0; call = 0; ret = 0;
      branch = 0; branch_ne = 0; alu_zero = 0; imm = '0; jmp_off = '0;
   endtask

   // Advance one edge and settle away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_jump(input logic [11:0] off);
      idle(); jump = 1; jmp_off = off; tick(); idle();
   endtask

   task automatic do_call(input logic [11:0] off);
      idle(); call = 1; jmp_off = off; tick(); idle();
   endtask

   task automatic do_ret();
      idle(); ret = 1; tick(); idle();
   endtask

   initial begin
      idle();
      rst = 1;
      tick(); tick();
      chk("reset_pc", pc, 16'h0000);
      chk("reset_redirect", redirect, 0);
      chk("reset_count", ras_count, 0);
      chk("reset_uf", ras_underflow, 0);

      // Sequential fetch after reset release
      rst = 0;
      chk("seq_next", pc_next, 16'h0002);
      tick(); chk("seq_pc1", pc, 16'h0002); chk("seq_rd1", redirect, 0);
      tick(); chk("seq_pc2", pc, 16'h0004); chk("seq_rd2", redirect, 0);
      tick(); chk("seq_pc3", pc, 16'h0006); chk("seq_rd3", redirect, 0);

      // Branches around 0x0010
      do_jump(12'd4);
      chk("jmp_pc", pc, 16'h0010); chk("jmp_rd", redirect, 1);
      branch = 1; branch_ne = 0; alu_zero = 1; imm = 16'hFFFE;
      #1 chk("beq_next", pc_next, 16'h000E);
      tick(); idle();
      chk("beq_pc", pc, 16'h000E); chk("beq_rd", redirect, 1);
      do_jump(12'd0);
      chk("jmp0_pc", pc, 16'h0010);
      branch = 1; branch_ne = 1; alu_zero = 1; imm = 16'hFFFE;
      tick(); idle();
      chk("bne_pc", pc, 16'h0012); chk("bne_rd", redirect, 0);

      // Call / return
      do_jump(12'd6);
      chk("to20_pc", pc, 16'h0020);
      do_call(12'h010);
      chk("call_pc", pc, 16'h0042); chk("call_cnt", ras_count, 1); chk("call_rd", redirect, 1);
      do_jump(12'd6);
      chk("to50_pc", pc, 16'h0050);
      do_ret();
      chk("ret_pc", pc, 16'h0022); chk("ret_cnt", ras_count, 0); chk("ret_rd", redirect, 1);

      // Overflow: five calls from 0x100..0x500
      do_jump(12'h06E);
      chk("to100_pc", pc, 16'h0100);
      do_call(12'h07F); chk("c1_cnt", ras_count, 1);
      do_call(12'h07F); chk("c2_cnt", ras_count, 2);
      do_call(12'h07F); chk("c3_cnt", ras_count, 3);
      do_call(12'h07F); chk("c4_cnt", ras_count, 4);
      do_call(12'h07F); chk("c5_cnt", ras_count, 4);
      chk("c5_pc", pc, 16'h0600);
      do_ret(); chk("r1_pc", pc, 16'h0502); chk("r1_cnt", ras_count, 3);
      do_ret(); chk("r2_pc", pc, 16'h0402); chk("r2_cnt", ras_count, 2);
      do_ret(); chk("r3_pc", pc, 16'h0302); chk("r3_cnt", ras_count, 1);
      do_ret(); chk("r4_pc", pc, 16'h0202); chk("r4_cnt", ras_count, 0);
      chk("r4_uf", ras_underflow, 0);
      do_ret();
      chk("r5_pc", pc, 16'h0204); chk("r5_uf", ras_underflow, 1);
      chk("r5_rd", redirect, 0); chk("r5_cnt", ras_count, 0);
      tick();
      chk("uf_clear", ras_underflow, 0); chk("uf_pc", pc, 16'h0206);

      // Stall blocks call; trap overrides stall without touching the RAS
      do_jump(12'd0);
      chk("to208_pc", pc, 16'h0208); chk("to208_rd", redirect, 1);
      stall = 1; call = 1; jmp_off = 12'd5;
      tick();
      chk("stall_pc", pc, 16'h0208); chk("stall_cnt", ras_count, 0); chk("stall_rd", redirect, 0);
      trap = 1;
      tick(); idle();
      chk("trap_pc", pc, 16'h0004); chk("trap_rd", redirect, 1); chk("trap_cnt", ras_count, 0);

      // Negative offset wraps below zero
      do_jump(12'hFFC);
      chk("wrap_pc", pc, 16'hFFFE);
      tick();
      chk("wrap_seq", pc, 16'h0000);

      // Reset in the middle of activity
      do_call(12'd0); do_call(12'd0); do_call(12'd0);
      chk("pre_cnt", ras_count, 3); chk("pre_pc6", pc, 16'h0006);
      do_jump(12'h17C);
      chk("pre_pc", pc, 16'h0300);
      rst = 1; ret = 1;
      tick(); idle(); rst = 0;
      chk("mrst_pc", pc, 16'h0000); chk("mrst_cnt", ras_count, 0);
      chk("mrst_rd", redirect, 0); chk("mrst_uf", ras_underflow, 0);
      tick();
      chk("post_pc", pc, 16'h0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
